// File: rtl/player_input_checker_pkg.sv
// Shared constants, FSM state codes and key helpers for the player input checker.
// Default cycle counts assume a 50 MHz board clock.
package player_input_checker_pkg;

  localparam int   TILE_W                  = 2;
  localparam logic KEY_ACTIVE_LOW          = 1'b1;
  localparam int   CLOCK_HZ                = 50_000_000;
  localparam int   DEFAULT_SEQ_LEN         = 9;
  localparam int   DEFAULT_DEBOUNCE_CYCLES = CLOCK_HZ / 100;
  localparam int   DEFAULT_TIMEOUT_CYCLES  = CLOCK_HZ * 5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE         = 3'd0;
  localparam state_t ST_WAIT_PRESS   = 3'd1;
  localparam state_t ST_WAIT_RELEASE = 3'd2;
  localparam state_t ST_PASS         = 3'd3;
  localparam state_t ST_FAIL         = 3'd4;

  function automatic logic isOneHot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [TILE_W-1:0] keyToTile(input logic [3:0] v);
    logic [TILE_W-1:0] t;
    t = '0;
    for (int k = 0; k < 4; k++) begin
      if (v[k]) t = TILE_W'(k);
    end
    return t;
  endfunction

endpackage

// File: rtl/player_input_checker_key_debouncer.sv
// Synchronises the four board keys and only passes on a key vector once it
// has held still for DEBOUNCE_CYCLES consecutive cycles.
module player_input_checker_key_debouncer
  import player_input_checker_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [3:0] i_raw,
  output logic [3:0] o_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_last;
  logic [3:0]       r_stable;
  logic [CNT_W-1:0] r_count;

  // Keys are asynchronous to the clock, so they cross two flops before use.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_last   <= '0;
      r_stable <= '0;
      r_count  <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_last) begin
        r_last  <= r_sync2;
        r_count <= '0;
      end else if (r_count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_last;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/player_input_checker.sv
// Checks debounced KEY presses against the latched tile sequence for one round
// and reports pass/fail pulses plus a saturating score.
module player_input_checker
  import player_input_checker_pkg::*;
#(
  parameter int SEQ_LEN         = DEFAULT_SEQ_LEN,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [2*SEQ_LEN-1:0]    i_seq,
  input  logic [3:0]              i_round_len,
  input  logic [3:0]              i_key_n,
  output logic                    o_busy,
  output logic                    o_press_valid,
  output logic [TILE_W-1:0]       o_press_tile,
  output logic [3:0]              o_index,
  output logic                    o_pass,
  output logic                    o_fail,
  output logic [7:0]              o_score
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [3:0]          w_keys;
  logic [3:0]          w_db;
  logic [3:0]          w_len;
  logic [TILE_W-1:0]   w_expTile;
  logic [TILE_W-1:0]   w_pressTile;

  state_t              r_state;
  logic [2*SEQ_LEN-1:0] r_seq;
  logic [3:0]          r_len;
  logic [3:0]          r_index;
  logic [TO_W-1:0]     r_timeout;
  logic                r_armed;
  logic                r_pressValid;
  logic [TILE_W-1:0]   r_pressTile;
  logic                r_pass;
  logic                r_fail;
  logic [7:0]          r_score;

  assign w_keys      = KEY_ACTIVE_LOW ? ~i_key_n : i_key_n;
  assign w_len       = (i_round_len > 4'(SEQ_LEN)) ? 4'(SEQ_LEN) : i_round_len;
  assign w_pressTile = keyToTile(w_db);

  player_input_checker_key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_raw   (w_keys),
    .o_stable(w_db)
  );

  always_comb begin
    w_expTile = '0;
    for (int t = 0; t < SEQ_LEN; t++) begin
      if (r_index == 4'(t)) w_expTile = r_seq[t*TILE_W +: TILE_W];
    end
  end

  // A key already down at start must be seen released (armed) before it counts;
  // a press decision in the same cycle as timeout expiry takes precedence.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_seq        <= '0;
      r_len        <= '0;
      r_index      <= '0;
      r_timeout    <= '0;
      r_armed      <= 1'b0;
      r_pressValid <= 1'b0;
      r_pressTile  <= '0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_score      <= '0;
    end else begin
      r_pressValid <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_seq     <= i_seq;
            r_len     <= w_len;
            r_index   <= '0;
            r_timeout <= '0;
            r_armed   <= 1'b0;
            r_state   <= (w_len == 4'd0) ? ST_PASS : ST_WAIT_PRESS;
          end
        end
        ST_WAIT_PRESS: begin
          if (w_db == 4'd0) r_armed <= 1'b1;
          if (r_armed && (w_db != 4'd0)) begin
            if (isOneHot(w_db)) begin
              r_pressValid <= 1'b1;
              r_pressTile  <= w_pressTile;
              r_state      <= (w_pressTile == w_expTile) ? ST_WAIT_RELEASE : ST_FAIL;
            end else begin
              r_state <= ST_FAIL;
            end
          end else if (r_timeout == TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_state <= ST_FAIL;
          end else begin
            r_timeout <= r_timeout + 1'b1;
          end
        end
        ST_WAIT_RELEASE: begin
          if (w_db == 4'd0) begin
            if (r_index == (r_len - 4'd1)) begin
              r_state <= ST_PASS;
            end else begin
              r_index   <= r_index + 4'd1;
              r_timeout <= '0;
              r_state   <= ST_WAIT_PRESS;
            end
          end
        end
        ST_PASS: begin
          r_pass  <= 1'b1;
          if (r_score != 8'hFF) r_score <= r_score + 8'd1;
          r_state <= ST_IDLE;
        end
        ST_FAIL: begin
          r_fail  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy        = (r_state != ST_IDLE);
  assign o_press_valid = r_pressValid;
  assign o_press_tile  = r_pressTile;
  assign o_index       = r_index;
  assign o_pass        = r_pass;
  assign o_fail        = r_fail;
  assign o_score       = r_score;

endmodule

// File: tb/tb_player_input_checker.sv
// Bench for player_input_checker: table vectors, hand-written corner sequences
// and random rounds compared against a round-level reference model.
module tb_player_input_checker;

  localparam int DB = 4;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] seqIn;
  logic [3:0]  rlIn;
  logic [3:0]  keyN;
  logic        busy;
  logic        pressValid;
  logic [1:0]  pressTile;
  logic [3:0]  index;
  logic        pass;
  logic        fail;
  logic [7:0]  score;

  always #5 clk = ~clk;

  player_input_checker #(
    .SEQ_LEN(9), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_seq(seqIn),
    .i_round_len(rlIn), .i_key_n(keyN), .o_busy(busy),
    .o_press_valid(pressValid), .o_press_tile(pressTile), .o_index(index),
    .o_pass(pass), .o_fail(fail), .o_score(score)
  );

  int total = 0;
  int bad   = 0;
  int modelScore = 0;

  int cyc = 0, busyRiseCyc = 0, failCyc = 0;
  int passPulses = 0, failPulses = 0, bothHigh = 0, pvIdle = 0;
  logic prevBusy = 1'b0;
  logic [1:0] pressQ[$];
  logic [1:0] expQ[$];

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (busy && !prevBusy) busyRiseCyc = cyc;
    prevBusy = busy;
    if (pressValid) pressQ.push_back(pressTile);
    if (pass) passPulses++;
    if (fail) begin failPulses++; failCyc = cyc; end
    if (pass && fail) bothHigh++;
    if (pressValid && !busy) pvIdle++;
  end

  initial begin
    #800_000;
    $display("[TB] FAIL watchdog actual=hung required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic pressKey(input logic [3:0] v);
    keyN = ~v;
    tick(10);
    keyN = 4'hF;
    tick(10);
  endtask

  task automatic pulseStart(input logic [17:0] s, input logic [3:0] rl);
    seqIn = s;
    rlIn  = rl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [17:0] s, input logic [3:0] rl, input int n,
                               input logic [63:0] keys);
    int w;
    pulseStart(s, rl);
    seqIn = 18'($urandom);
    rlIn  = 4'($urandom);
    for (int p = 0; p < n; p++) pressKey(keys[4*p +: 4]);
    w = 0;
    while (busy && w < 400) begin tick(); w++; end
    checkOutput("roundEnds", {31'd0, busy}, 0);
    tick(3);
  endtask

  // Reference: walk the presses at round level, one decision per accepted vector.
  task automatic modelRound(input logic [17:0] s, input logic [3:0] rl, input int n,
                            input logic [63:0] keys, output bit mPass, output logic [3:0] mIdx);
    int len, i, k;
    bit done;
    logic [3:0] v;
    len = (rl > 9) ? 9 : int'(rl);
    i = 0; done = 0; mPass = 0;
    expQ.delete();
    if (len == 0) begin mPass = 1; done = 1; end
    for (int p = 0; p < n && !done; p++) begin
      v = keys[4*p +: 4];
      if ($countones(v) > 1) done = 1;
      else if ($countones(v) == 1) begin
        k = 0;
        for (int b = 0; b < 4; b++) if (v[b]) k = b;
        expQ.push_back(2'(k));
        if (2'(k) != s[2*i +: 2]) done = 1;
        else if (i == len - 1) begin mPass = 1; done = 1; end
        else i++;
      end
    end
    mIdx = 4'(i);
  endtask

  task automatic runRound(input string tag, input logic [17:0] s, input logic [3:0] rl,
                          input int n, input logic [63:0] keys, output int passD,
                          output int failD, output int nPress, output logic [1:0] lastTile);
    int p0, f0;
    bit mPass;
    logic [3:0] mIdx;
    modelRound(s, rl, n, keys, mPass, mIdx);
    p0 = passPulses; f0 = failPulses;
    pressQ.delete();
    applyStimulus(s, rl, n, keys);
    passD = passPulses - p0;
    failD = failPulses - f0;
    nPress = pressQ.size();
    lastTile = (nPress > 0) ? pressQ[nPress-1] : 2'd0;
    checkOutput({tag, ".pass"}, passD, mPass ? 1 : 0);
    checkOutput({tag, ".fail"}, failD, mPass ? 0 : 1);
    checkOutput({tag, ".presses"}, nPress, expQ.size());
    for (int i = 0; i < expQ.size() && i < nPress; i++)
      checkOutput({tag, ".tile"}, pressQ[i], expQ[i]);
    checkOutput({tag, ".index"}, index, mIdx);
    if (mPass && modelScore < 255) modelScore++;
    checkOutput({tag, ".score"}, score, modelScore);
  endtask

  typedef struct {
    logic [17:0] seq;
    logic [3:0]  roundLen;
    int          nPress;
    logic [63:0] keys;
    bit          expPass;
    int          expPresses;
    logic [3:0]  expIndex;
    logic [1:0]  expLastTile;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int passD, failD, nPress, w, f0, p0, len, n;
    logic [1:0] lastTile;
    logic [17:0] s;
    logic [3:0] rl, v;
    logic [63:0] keys;
    int a, b;

    vecs[0] = '{18'h000E4, 4'd4,  4, 64'h8421,             1, 4, 4'd3, 2'd3};
    vecs[1] = '{18'h000E4, 4'd4,  2, 64'h41,               0, 2, 4'd1, 2'd2};
    vecs[2] = '{18'h000E4, 4'd4,  1, 64'h3,                0, 0, 4'd0, 2'd0};
    vecs[3] = '{18'h2391B, 4'd12, 9, 64'h0000000418421248, 1, 9, 4'd8, 2'd2};
    vecs[4] = '{18'h000E4, 4'd2,  2, 64'h21,               1, 2, 4'd1, 2'd1};
    vecs[5] = '{18'h000E4, 4'd1,  1, 64'h2,                0, 1, 4'd0, 2'd1};

    rst = 1'b1; start = 1'b0; seqIn = '0; rlIn = '0; keyN = 4'hF;
    tick(3);
    rst = 1'b0;
    tick();
    checkOutput("reset.busy", {31'd0, busy}, 0);
    checkOutput("reset.pressValid", {31'd0, pressValid}, 0);
    checkOutput("reset.pressTile", pressTile, 0);
    checkOutput("reset.index", index, 0);
    checkOutput("reset.pass", {31'd0, pass}, 0);
    checkOutput("reset.fail", {31'd0, fail}, 0);
    checkOutput("reset.score", score, 0);

    for (int i = 0; i < 6; i++) begin
      runRound($sformatf("vec%0d", i), vecs[i].seq, vecs[i].roundLen, vecs[i].nPress,
               vecs[i].keys, passD, failD, nPress, lastTile);
      checkOutput($sformatf("vec%0d.tblPass", i), passD, vecs[i].expPass ? 1 : 0);
      checkOutput($sformatf("vec%0d.tblPresses", i), nPress, vecs[i].expPresses);
      checkOutput($sformatf("vec%0d.tblIndex", i), index, vecs[i].expIndex);
      if (vecs[i].expPresses > 0)
        checkOutput($sformatf("vec%0d.tblLastTile", i), lastTile, vecs[i].expLastTile);
    end

    // round_len = 0 passes two cycles after start
    p0 = passPulses;
    pressQ.delete();
    pulseStart(18'h000E4, 4'd0);
    checkOutput("len0.passEarly", {31'd0, pass}, 0);
    checkOutput("len0.busy", {31'd0, busy}, 1);
    tick();
    checkOutput("len0.pass", {31'd0, pass}, 1);
    checkOutput("len0.busyLow", {31'd0, busy}, 0);
    modelScore++;
    tick(3);
    checkOutput("len0.presses", pressQ.size(), 0);
    checkOutput("len0.score", score, modelScore);

    // bouncing key then timeout
    pressQ.delete();
    f0 = failPulses;
    pulseStart(18'h000E4, 4'd4);
    for (int t = 0; t < 20; t++) begin keyN[1] = ~keyN[1]; tick(2); end
    keyN = 4'hF;
    w = 0;
    while (!fail && w < 200) begin tick(); w++; end
    checkOutput("bounce.failSeen", {31'd0, fail}, 1);
    tick(2);
    checkOutput("bounce.latency", failCyc - busyRiseCyc, TO + 1);
    checkOutput("bounce.failCount", failPulses - f0, 1);
    checkOutput("bounce.presses", pressQ.size(), 0);
    checkOutput("bounce.score", score, modelScore);

    // key held across start is ignored until released and pressed again
    pressQ.delete();
    keyN = 4'b1110;
    tick(12);
    pulseStart(18'h000E4, 4'd4);
    tick(20);
    checkOutput("held.noPress", pressQ.size(), 0);
    keyN = 4'hF;
    tick(10);
    pressKey(4'b0001);
    checkOutput("held.presses", pressQ.size(), 1);
    checkOutput("held.index", index, 1);

    // start while busy is ignored
    pulseStart(18'h00000, 4'd1);
    checkOutput("busyStart.index", index, 1);
    checkOutput("busyStart.busy", {31'd0, busy}, 1);
    p0 = passPulses;
    pressKey(4'b0010);
    pressKey(4'b0100);
    pressKey(4'b1000);
    tick(3);
    checkOutput("busyStart.pass", passPulses - p0, 1);
    modelScore++;
    checkOutput("busyStart.score", score, modelScore);

    // random rounds against the model
    for (int r = 0; r < 25; r++) begin
      s  = 18'($urandom);
      rl = 4'($urandom_range(0, 15));
      len = (rl > 9) ? 9 : int'(rl);
      n = (len == 0) ? 0 : int'($urandom_range(1, len));
      keys = '0;
      for (int p = 0; p < n; p++) begin
        a = int'($urandom_range(0, 9));
        if (a < 7) v = 4'(1 << s[2*p +: 2]);
        else if (a < 9) v = 4'(1 << $urandom_range(0, 3));
        else begin
          a = int'($urandom_range(0, 3));
          b = (a + 1 + int'($urandom_range(0, 2))) % 4;
          v = 4'((1 << a) | (1 << b));
        end
        keys[4*p +: 4] = v;
      end
      runRound($sformatf("rand%0d", r), s, rl, n, keys, passD, failD, nPress, lastTile);
    end

    // reset in WAIT_RELEASE, with start in the same cycle
    pulseStart(18'h000E6, 4'd4);
    keyN = 4'b1011;
    tick(10);
    checkOutput("midReset.preTile", pressTile, 2);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    checkOutput("midReset.busy", {31'd0, busy}, 0);
    checkOutput("midReset.pressValid", {31'd0, pressValid}, 0);
    checkOutput("midReset.pressTile", pressTile, 0);
    checkOutput("midReset.index", index, 0);
    checkOutput("midReset.passFail", {30'd0, pass, fail}, 0);
    checkOutput("midReset.score", score, 0);
    modelScore = 0;
    tick();
    checkOutput("midReset.startIgnored", {31'd0, busy}, 0);
    keyN = 4'hF;
    tick(10);

    // score saturation
    while (modelScore < 255) begin
      pulseStart(18'h0, 4'd0);
      tick(3);
      modelScore++;
    end
    checkOutput("sat.score255", score, 255);
    p0 = passPulses;
    pulseStart(18'h0, 4'd0);
    tick(3);
    checkOutput("sat.passAgain", passPulses - p0, 1);
    checkOutput("sat.held", score, 255);

    checkOutput("inv.passAndFail", bothHigh, 0);
    checkOutput("inv.pressValidIdle", pvIdle, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
